// File: rtl/ef_smsdac_spi_feeder.sv
// Paced sample source for the mismatch-shaping DAC: 3-wire SPI slave into a small FIFO, or parallel bypass.
// d_out is registered (1 clk); no backpressure: a full FIFO drops words (ovf), an empty-FIFO tick holds d_out (udf).
module ef_smsdac_spi_feeder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  RESET_VAL = 8'h80
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     spi_sclk,
  input  logic                     spi_cs_b,
  input  logic                     spi_mosi,
  input  logic [7:0]               d_par,
  input  logic                     src_sel,
  input  logic [7:0]               rate_div,
  input  logic                     clr_flags,
  output logic [7:0]               d_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf,
  output logic                     udf
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic             sclk_s1, sclk_s2, sclk_s3;
  logic             cs_b_s1, cs_b_s2;
  logic             mosi_s1, mosi_s2;
  // The 8th bit goes straight into the pushed word, so only 7 bits are stored.
  logic [6:0]       shift;
  logic [2:0]       bit_cnt;
  logic [7:0]       mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, used;
  logic [7:0]       rate_cnt;
  logic [7:0]       rx_word;
  logic             sclk_rise, push_req, push, pop, tick, full, empty;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign rx_word   = {shift, mosi_s2};
  assign push_req  = sclk_rise & ~cs_b_s2 & (bit_cnt == 3'd7);
  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == FULL_LVL);
  assign empty     = (wr_ptr == rd_ptr);
  assign tick      = src_sel & (rate_cnt >= rate_div);
  assign pop       = tick & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push      = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sclk_s1    <= 1'b0;
      sclk_s2    <= 1'b0;
      sclk_s3    <= 1'b0;
      cs_b_s1    <= 1'b1;
      cs_b_s2    <= 1'b1;
      mosi_s1    <= 1'b0;
      mosi_s2    <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rate_cnt   <= '0;
      d_out      <= RESET_VAL;
      fifo_level <= '0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else begin
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_b_s1 <= spi_cs_b;
      cs_b_s2 <= cs_b_s1;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;

      if (cs_b_s2) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift   <= rx_word[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      fifo_level <= used;

      if (!src_sel)  rate_cnt <= '0;
      else if (tick) rate_cnt <= '0;
      else           rate_cnt <= rate_cnt + 8'd1;

      if (!src_sel) d_out <= d_par;
      else if (pop) d_out <= mem[rd_ptr[AW-1:0]];

      ovf <= (ovf & ~clr_flags) | (push_req & ~push);
      udf <= (udf & ~clr_flags) | (tick & empty);
    end
  end
endmodule

// File: tb/tb_ef_smsdac_spi_feeder.sv
// Randomized bench for ef_smsdac_spi_feeder: stimulus queues expected words, a negedge monitor checks d_out.
module tb_ef_smsdac_spi_feeder;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_b, spi_sclk, spi_cs_b, spi_mosi, src_sel, clr_flags;
  logic [7:0]    d_par, rate_div, d_out;
  logic [LW-1:0] fifo_level;
  logic          ovf, udf;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  int            c0;
  logic          watch_en = 1'b0;
  logic [7:0]    last_seen;
  logic [7:0]    exp_q[$];
  int            chg_q[$];
  logic [7:0]    v [DEPTH+1];

  ef_smsdac_spi_feeder #(.DEPTH(DEPTH), .RESET_VAL(8'h80)) dut (
    .clk(clk), .rst_b(rst_b), .spi_sclk(spi_sclk), .spi_cs_b(spi_cs_b),
    .spi_mosi(spi_mosi), .d_par(d_par), .src_sel(src_sel), .rate_div(rate_div),
    .clr_flags(clr_flags), .d_out(d_out), .fifo_level(fifo_level), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every change of d_out while watching must be the next word the model expects.
  always @(negedge clk) begin
    if (!watch_en) begin
      last_seen = d_out;
    end else if (d_out !== last_seen) begin
      chg_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL d_out unexpected: got 0x%0h, expected no new word", d_out);
      end else begin
        chk("d_out order", d_out, exp_q.pop_front());
      end
      last_seen = d_out;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    spi_sclk = 1'b0; spi_mosi = b; step(4);
    spi_sclk = 1'b1; step(4);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_lo();
    spi_sclk = 1'b0; spi_cs_b = 1'b0; step(4);
  endtask

  task automatic cs_hi();
    spi_sclk = 1'b0; step(4);
    spi_cs_b = 1'b1; step(4);
  endtask

  function automatic logic [7:0] pick(input logic [7:0] avoid);
    logic [7:0] w;
    do w = 8'($urandom); while (w == avoid);
    return w;
  endfunction

  task automatic clear_flags_bypass();
    src_sel = 1'b0; watch_en = 1'b0; d_par = 8'h00;
    clr_flags = 1'b1; step(1);
    clr_flags = 1'b0; step(1);
  endtask

  initial begin
    // Reset with random functional inputs, SPI idle
    rst_b = 1'b0; spi_sclk = 1'b0; spi_cs_b = 1'b1; spi_mosi = 1'b0;
    d_par = 8'($urandom); src_sel = 1'($urandom); rate_div = 8'($urandom); clr_flags = 1'($urandom);
    step(2);
    chk("reset d_out", d_out, 8'h80);
    chk("reset level", fifo_level, 0);
    chk("reset ovf", ovf, 0);
    chk("reset udf", udf, 0);
    rst_b = 1'b1; src_sel = 1'b0; clr_flags = 1'b0; rate_div = 8'd0;

    // Bypass
    d_par = 8'h3C; step(1); chk("bypass 3C", d_out, 8'h3C);
    d_par = 8'hC3; step(1); chk("bypass C3", d_out, 8'hC3);
    chk("bypass level", fifo_level, 0);
    for (int i = 0; i < 6; i++) begin
      d_par = 8'($urandom); step(1); chk("bypass random", d_out, d_par);
    end

    // SPI stream preloaded while bypassed, then paced out at rate_div=9
    d_par = 8'h00; step(1);
    cs_lo(); spi_byte(8'hA5); spi_byte(8'h5A); cs_hi();
    chk("preload level", fifo_level, 2);
    exp_q = '{8'hA5, 8'h5A}; chg_q.delete();
    rate_div = 8'd9; src_sel = 1'b1; watch_en = 1'b1; c0 = cyc;
    step(40);
    chk("stream words seen", chg_q.size(), 2);
    if (chg_q.size() >= 1) chk("first tick delay", chg_q[0] - c0, 10);
    if (chg_q.size() >= 2) chk("pacing period", chg_q[1] - chg_q[0], 10);
    chk("stream drained", exp_q.size(), 0);
    chk("stream level", fifo_level, 0);
    chk("udf after drain", udf, 1);

    // Random back-to-back words at a random rate
    rate_div = 8'($urandom_range(6, 20));
    begin
      logic [7:0] prev;
      prev = 8'h5A;
      cs_lo();
      for (int i = 0; i < 6; i++) begin
        prev = pick(prev);
        exp_q.push_back(prev);
        spi_byte(prev);
      end
      cs_hi();
    end
    step(60);
    chk("random stream drained", exp_q.size(), 0);

    // Overflow: DEPTH+1 words while bypassed, only DEPTH survive
    clear_flags_bypass();
    chk("cleared ovf", ovf, 0);
    chk("cleared udf", udf, 0);
    v[0] = pick(8'h00);
    for (int i = 1; i <= DEPTH; i++) v[i] = pick(v[i-1]);
    cs_lo();
    for (int i = 0; i <= DEPTH; i++) spi_byte(v[i]);
    cs_hi();
    chk("ovf level", fifo_level, DEPTH);
    chk("ovf set", ovf, 1);
    chk("no udf in bypass", udf, 0);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(v[i]);
    rate_div = 8'd3; src_sel = 1'b1; watch_en = 1'b1;
    step(40);
    chk("ovf words drained", exp_q.size(), 0);
    chk("ovf level after", fifo_level, 0);

    // Underflow, aborted partial word, clear priority
    clear_flags_bypass();
    chk("udf cleared", udf, 0);
    rate_div = 8'd5; src_sel = 1'b1; watch_en = 1'b1;
    step(5);
    chk("udf before first tick", udf, 0);
    step(1);
    chk("udf at first tick", udf, 1);
    chk("d_out holds", d_out, 8'h00);
    exp_q.push_back(8'h11);
    cs_lo();
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    cs_hi();
    cs_lo(); spi_byte(8'h11); cs_hi();
    step(20);
    chk("abort only 11 seen", exp_q.size(), 0);
    rate_div = 8'd0;
    clr_flags = 1'b1; step(1); clr_flags = 1'b0;
    chk("set beats clear", udf, 1);
    clear_flags_bypass();
    chk("udf clr", udf, 0);
    chk("ovf clr", ovf, 0);

    // Full FIFO, rate_div=0, push landing on the first pop cycle
    v[0] = pick(8'h00);
    for (int i = 1; i <= DEPTH; i++) v[i] = pick(v[i-1]);
    cs_lo();
    for (int i = 0; i < DEPTH; i++) spi_byte(v[i]);
    for (int i = 7; i >= 1; i--) spi_bit(v[DEPTH][i]);
    spi_sclk = 1'b0; spi_mosi = v[DEPTH][0]; step(4);
    spi_sclk = 1'b1; step(2);
    chk("full before pop", fifo_level, DEPTH);
    for (int i = 0; i <= DEPTH; i++) exp_q.push_back(v[i]);
    chg_q.delete();
    src_sel = 1'b1; watch_en = 1'b1;
    step(2);
    chk("level held on push+pop", fifo_level, DEPTH);
    chk("no ovf on push+pop", ovf, 0);
    cs_hi();
    step(10);
    chk("boundary drained", exp_q.size(), 0);
    chk("boundary words seen", chg_q.size(), DEPTH + 1);
    for (int i = 1; i < chg_q.size(); i++) chk("one word per clk", chg_q[i] - chg_q[i-1], 1);
    watch_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
